// File: rtl/riscv_pkg.sv
// Shared RISC-V load-path definitions: load_control encodings (equal to funct3),
// load-unit state type and the alignment rule.
package riscv_pkg;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WB,
        FAULT
    } load_state_t;

    // Halves need an even address, words need a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] off);
        logic mis;
        case (ctrl)
            LH, LHU: mis = off[0];
            LW:      mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/half/word from a read word and sign- or zero-extends it.
// Purely combinational; shared with the store/forwarding path.
module load_extract
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_offset,
    input  logic [2:0]      i_load_control,
    output logic [XLEN-1:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

        // Unknown encodings fall through to LB.
        case (i_load_control)
            LH:      o_result = {{(XLEN-16){w_half[15]}}, w_half};
            LW:      o_result = i_rdata;
            LBU:     o_result = {{(XLEN-8){1'b0}}, w_byte};
            LHU:     o_result = {{(XLEN-16){1'b0}}, w_half};
            default: o_result = {{(XLEN-8){w_byte[7]}}, w_byte};
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load execute/memory stage: forms the effective address, performs one word read,
// extracts the result and issues a one-cycle write-back or fault pulse.
module load_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [XLEN-1:0] i_rs1_value,
    input  logic [11:0]     i_imm,
    input  logic [4:0]      i_rd,
    input  logic [2:0]      i_load_control,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    input  logic            i_mem_gnt,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_wb_en,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_misaligned,
    output logic            o_access_fault,
    output logic [XLEN-1:0] o_fault_addr
);

    localparam int unsigned    CntW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    load_state_t     r_state, w_state_next;
    logic [XLEN-1:0] r_ea;
    logic [4:0]      r_rd;
    logic [2:0]      r_ctrl;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic            r_timeout;
    logic [XLEN-1:0] r_mem_addr, r_wb_data, r_fault_addr;
    logic [4:0]      r_wb_rd;

    logic [XLEN-1:0] w_ea;
    logic [XLEN-1:0] w_extracted;
    logic            w_accept, w_mis, w_timeout, w_latch;

    assign w_ea     = i_rs1_value + {{(XLEN-12){i_imm[11]}}, i_imm};
    assign w_accept = i_in_valid && (r_state == IDLE);
    assign w_mis    = is_misaligned(i_load_control, w_ea[1:0]);

    load_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .i_rdata        (i_mem_rdata),
        .i_offset       (r_ea[1:0]),
        .i_load_control (r_ctrl),
        .o_result       (w_extracted)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_timeout    = 1'b0;
        w_latch      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_mis ? FAULT : REQ;
                    w_cnt_next   = '0;
                end
            end
            REQ: begin
                if (i_mem_gnt && i_mem_rvalid) begin
                    w_state_next = WB;
                    w_latch      = 1'b1;
                end else if (i_mem_gnt) begin
                    w_state_next = WAIT;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (w_cnt_next == CntMax) begin
                        w_state_next = FAULT;
                        w_timeout    = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (i_mem_rvalid) begin
                    w_state_next = WB;
                    w_latch      = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (w_cnt_next == CntMax) begin
                        w_state_next = FAULT;
                        w_timeout    = 1'b1;
                    end
                end
            end
            WB:      w_state_next = IDLE;
            FAULT:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_ea         <= '0;
            r_rd         <= '0;
            r_ctrl       <= '0;
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
            r_mem_addr   <= '0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_fault_addr <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_ea      <= w_ea;
                r_rd      <= i_rd;
                r_ctrl    <= i_load_control;
                r_timeout <= 1'b0;
                if (w_mis) begin
                    r_fault_addr <= w_ea;
                end else begin
                    r_mem_addr <= {w_ea[XLEN-1:2], 2'b00};
                end
            end
            if (w_timeout) begin
                r_timeout    <= 1'b1;
                r_fault_addr <= r_ea;
            end
            // x0 loads never update the visible write-back value.
            if (w_latch && (r_rd != 5'd0)) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_extracted;
            end
        end
    end

    assign o_in_ready     = (r_state == IDLE);
    assign o_mem_req      = (r_state == REQ);
    assign o_mem_addr     = r_mem_addr;
    assign o_wb_en        = (r_state == WB) && (r_rd != 5'd0);
    assign o_wb_rd        = r_wb_rd;
    assign o_wb_data      = r_wb_data;
    assign o_misaligned   = (r_state == FAULT) && !r_timeout;
    assign o_access_fault = (r_state == FAULT) && r_timeout;
    assign o_fault_addr   = r_fault_addr;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: a queue of expected events built from a
// transaction-level load model, checked by one negedge compare process.
module tb_load_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_in_valid, o_in_ready;
    logic [31:0] i_rs1_value;
    logic [11:0] i_imm;
    logic [4:0]  i_rd;
    logic [2:0]  i_load_control;
    logic        o_mem_req, i_mem_gnt, i_mem_rvalid;
    logic [31:0] o_mem_addr, i_mem_rdata;
    logic        o_wb_en, o_misaligned, o_access_fault;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data, o_fault_addr;

    load_unit #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_in_valid     (i_in_valid),
        .o_in_ready     (o_in_ready),
        .i_rs1_value    (i_rs1_value),
        .i_imm          (i_imm),
        .i_rd           (i_rd),
        .i_load_control (i_load_control),
        .o_mem_req      (o_mem_req),
        .o_mem_addr     (o_mem_addr),
        .i_mem_gnt      (i_mem_gnt),
        .i_mem_rvalid   (i_mem_rvalid),
        .i_mem_rdata    (i_mem_rdata),
        .o_wb_en        (o_wb_en),
        .o_wb_rd        (o_wb_rd),
        .o_wb_data      (o_wb_data),
        .o_misaligned   (o_misaligned),
        .o_access_fault (o_access_fault),
        .o_fault_addr   (o_fault_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          fault;
        bit          mis;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] addr;
        int          lat;
    } exp_t;

    exp_t        expq[$];
    exp_t        ce;
    int          acc_cyc      = 0;
    int          last_evt_cyc = 0;
    logic [31:0] exp_mem_addr = '0;
    bit          req_ok       = 1'b0;

    // Architectural load result from the word, the byte address and the encoding.
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] ea,
                                               input logic [2:0] ctrl);
        int unsigned b, h;
        b = (word >> (ea % 4 * 8)) & 32'hFF;
        h = (word >> ((ea % 4) / 2 * 16)) & 32'hFFFF;
        case (ctrl)
            LH:      return (h >= 32'h8000) ? h - 32'h1_0000 : h;
            LW:      return word;
            LBU:     return b;
            LHU:     return h;
            default: return (b >= 32'h80) ? b - 32'h100 : b;
        endcase
    endfunction

    function automatic bit model_mis(input logic [2:0] ctrl, input logic [31:0] ea);
        return (ctrl == LW && ea % 4 != 0) || ((ctrl == LH || ctrl == LHU) && ea % 2 != 0);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (o_mem_req) begin
                chk("mem_req_allowed", {31'd0, req_ok}, 32'd1);
                chk("mem_addr", o_mem_addr, exp_mem_addr);
            end
            if (o_wb_en || o_misaligned || o_access_fault) begin
                last_evt_cyc = cyc;
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: wb_en=%b misaligned=%b access_fault=%b, required none",
                             o_wb_en, o_misaligned, o_access_fault);
                end else begin
                    ce = expq.pop_front();
                    chk("event_kind", {29'd0, o_wb_en, o_misaligned, o_access_fault},
                        ce.fault ? {29'd0, 1'b0, ce.mis, !ce.mis} : 32'd4);
                    chk("event_latency", cyc - acc_cyc, ce.lat);
                    if (ce.fault) begin
                        chk("fault_addr", o_fault_addr, ce.addr);
                    end else begin
                        chk("wb_rd", {27'd0, o_wb_rd}, {27'd0, ce.rd});
                        chk("wb_data", o_wb_data, ce.data);
                    end
                end
            end
        end
    end

    // gdly: REQ cycles before gnt (<0 = never); rdly: cycles from gnt to rvalid (<0 = never).
    task automatic do_load(input logic [31:0] rs1, input logic [11:0] imm, input logic [4:0] rd,
                           input logic [2:0] ctrl, input logic [31:0] word,
                           input int gdly, input int rdly);
        logic [31:0] ea;
        bit          mis;
        exp_t        e;
        int          n;
        ea  = rs1 + 32'($signed(imm));
        mis = model_mis(ctrl, ea);
        n = 0;
        while (!o_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", {31'd0, o_in_ready}, 32'd1);
        e.fault = mis || gdly < 0 || rdly < 0;
        e.mis   = mis;
        e.rd    = rd;
        e.addr  = ea;
        e.data  = model_load(word, ea, ctrl);
        e.lat   = mis ? 1 : (gdly < 0) ? 256 : (rdly < 0) ? 257 + gdly : 2 + gdly + rdly;
        if (e.fault || rd != 5'd0) expq.push_back(e);
        exp_mem_addr   = {ea[31:2], 2'b00};
        req_ok         = !mis;
        acc_cyc        = cyc;
        i_in_valid     = 1'b1;
        i_rs1_value    = rs1;
        i_imm          = imm;
        i_rd           = rd;
        i_load_control = ctrl;
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        if (!mis && gdly >= 0) begin
            repeat (gdly) begin
                @(posedge clk);
                #1;
            end
            i_mem_gnt = 1'b1;
            if (rdly == 0) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = word;
            end
            @(posedge clk);
            #1;
            i_mem_gnt    = 1'b0;
            i_mem_rvalid = 1'b0;
            if (rdly > 0) begin
                repeat (rdly - 1) begin
                    @(posedge clk);
                    #1;
                end
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = word;
                @(posedge clk);
                #1;
                i_mem_rvalid = 1'b0;
            end
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_in_ready && n < 400);
        chk("idle_after_load", {31'd0, o_in_ready}, 32'd1);
        req_ok = 1'b0;
        if (e.fault || rd != 5'd0) chk("ready_cycle_after_event", cyc, last_evt_cyc + 1);
        chk("pending_empty", expq.size(), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, o_in_ready}, 32'd1);
        chk({tag, "_pulses"}, {28'd0, o_mem_req, o_wb_en, o_misaligned, o_access_fault}, 32'd0);
        chk({tag, "_mem_addr"}, o_mem_addr, 32'd0);
        chk({tag, "_wb_rd"}, {27'd0, o_wb_rd}, 32'd0);
        chk({tag, "_wb_data"}, o_wb_data, 32'd0);
        chk({tag, "_fault_addr"}, o_fault_addr, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        i_in_valid     = 1'b0;
        i_rs1_value    = '0;
        i_imm          = '0;
        i_rd           = '0;
        i_load_control = '0;
        i_mem_gnt      = 1'b0;
        i_mem_rvalid   = 1'b0;
        i_mem_rdata    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        do_load(32'h1000, 12'h003, 5'd1, LB, 32'h80FF_1234, 0, 1);
        chk("lb_mem_addr", o_mem_addr, 32'h0000_1000);
        chk("lb_data", o_wb_data, 32'hFFFF_FF80);
        do_load(32'h1000, 12'h003, 5'd2, LBU, 32'h80FF_1234, 0, 1);
        chk("lbu_data", o_wb_data, 32'h0000_0080);
        do_load(32'h1000, 12'h002, 5'd3, LHU, 32'h80FF_1234, 0, 1);
        chk("lhu_data", o_wb_data, 32'h0000_80FF);
        do_load(32'h1000, 12'h002, 5'd4, LH, 32'h80FF_1234, 0, 1);
        chk("lh_data", o_wb_data, 32'hFFFF_80FF);
        do_load(32'h2000, 12'hFFC, 5'd5, LW, 32'hDEAD_BEEF, 0, 1);
        chk("lw_neg_mem_addr", o_mem_addr, 32'h0000_1FFC);
        chk("lw_neg_data", o_wb_data, 32'hDEAD_BEEF);

        do_load(32'h1002, 12'h000, 5'd6, LW, 32'h0, 0, 1);
        chk("mis_lw_addr", o_fault_addr, 32'h0000_1002);
        do_load(32'h1000, 12'h001, 5'd7, LH, 32'h0, 0, 1);
        chk("mis_lh_addr", o_fault_addr, 32'h0000_1001);

        do_load(32'h1000, 12'h001, 5'd8, LB, 32'h80FF_1234, 0, 1);
        chk("lb_pos_data", o_wb_data, 32'h0000_0012);
        do_load(32'h1000, 12'h003, 5'd9, 3'd3, 32'h80FF_1234, 0, 1);
        do_load(32'h1004, 12'h000, 5'd10, 3'd7, 32'h80FF_1234, 2, 2);
        do_load(32'h1000, 12'h000, 5'd11, LHU, 32'h80FF_1234, 3, 0);
        chk("lhu_same_cycle_data", o_wb_data, 32'h0000_1234);
        do_load(32'hFFFF_FFF0, 12'h014, 5'd12, LW, 32'hCAFE_F00D, 2, 4);
        chk("lw_wrap_mem_addr", o_mem_addr, 32'h0000_0004);
        do_load(32'h0800, 12'h000, 5'd13, LH, 32'h0000_8001, 0, 1);
        chk("lh_low_data", o_wb_data, 32'hFFFF_8001);

        do_load(32'h1000, 12'h000, 5'd0, LW, 32'h1122_3344, 0, 1);
        chk("rd0_hold_data", o_wb_data, 32'hFFFF_8001);
        chk("rd0_hold_rd", {27'd0, o_wb_rd}, 32'd13);

        do_load(32'h3000, 12'h000, 5'd14, LW, 32'h0, -1, 0);
        chk("timeout_req_addr", o_fault_addr, 32'h0000_3000);
        do_load(32'h5000, 12'h004, 5'd15, LW, 32'h0, 1, -1);
        chk("timeout_wait_addr", o_fault_addr, 32'h0000_5004);

        // Reset while waiting for read data; the late response must be dropped.
        i_in_valid     = 1'b1;
        i_rs1_value    = 32'h4000;
        i_imm          = 12'h008;
        i_rd           = 5'd9;
        i_load_control = LW;
        exp_mem_addr   = 32'h4008;
        req_ok         = 1'b1;
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        i_mem_gnt  = 1'b1;
        @(posedge clk);
        #1;
        i_mem_gnt = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        req_ok = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        i_mem_rvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_wb", {31'd0, o_wb_en}, 32'd0);
        end

        do_load(32'h1000, 12'h002, 5'd17, LBU, 32'h80FF_1234, 0, 1);
        chk("post_rst_data", o_wb_data, 32'h0000_00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
